// File: rtl/eq_regs_pkg.sv
// Shared definitions for the SPI register bridge: FSM states, command-byte
// field positions and the default register-map depth.
package eq_regs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 4;
  localparam int CMD_ADDR_LSB = 0;
  localparam int DEF_NUM_REGS = 31;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with rise/fall detection; o_valid marks the point
// after reset where the synchronized level reflects real input samples.
module sync_edge_det #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_VAL    = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_valid
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] r_vld;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{IDLE_VAL}};
      r_vld  <= '0;
      r_prev <= IDLE_VAL;
    end else begin
      r_sync <= SYNC_STAGES'({r_sync, i_async});
      r_vld  <= SYNC_STAGES'({r_vld, 1'b1});
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_prev;
  assign o_valid = r_vld[SYNC_STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI (mode 0) slave to register-map write bridge with address auto-increment.
// Optional readback path on miso is enabled by defining SPI_READBACK_EN.
module spi_reg_bridge
  import eq_regs_pkg::*;
#(
  parameter int ADDR_WIDTH  = 31,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            data_in,
  output logic                  busy,
  output logic                  frame_err
`ifdef SPI_READBACK_EN
  ,
  input  logic [7:0]            rd_data,
  output logic [ADDR_WIDTH-1:0] rd_addr
`endif
);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall, w_sclk_vld;
  logic w_cs_level, w_cs_rise, w_cs_fall, w_cs_vld;

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_sclk (
    .i_clk(clk), .i_rst_n(rst), .i_async(sclk),
    .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall), .o_valid(w_sclk_vld)
  );

  sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
    .i_clk(clk), .i_rst_n(rst), .i_async(cs_n),
    .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall), .o_valid(w_cs_vld)
  );

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   w_mosi;

  state_t                 r_state, w_state_nxt;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_shift;
  logic                   r_rw;
  logic                   r_armed;
  logic [ADDR_WIDTH-1:0]  r_cur_addr;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [7:0]             r_data;
  logic                   r_busy;
  logic                   r_frame_err;

  logic [7:0]             w_byte;
  logic                   w_in_frame;
  logic                   w_byte_done;
  logic                   w_frame_start;
  logic                   w_in_range;

  assign w_mosi        = r_mosi_sync[SYNC_STAGES-1];
  assign w_byte        = {r_shift, w_mosi};
  assign w_in_frame    = (r_state != ST_IDLE);
  assign w_byte_done   = w_sclk_rise && w_in_frame && (r_bit_cnt == 3'd7);
  // After reset, a frame may only start once cs_n has been seen high for real.
  assign w_frame_start = w_cs_fall && r_armed && (r_state == ST_IDLE);
  assign w_in_range    = (r_cur_addr < ADDR_WIDTH'(NUM_REGS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_frame_start) w_state_nxt = ST_CMD;
      ST_CMD:  if (w_byte_done)   w_state_nxt = ST_DATA;
      ST_DATA: w_state_nxt = ST_DATA;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_cs_rise) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mosi_sync <= '0;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 7'd0;
      r_rw        <= 1'b0;
      r_armed     <= 1'b0;
      r_cur_addr  <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= 8'h00;
      r_busy      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_mosi_sync <= SYNC_STAGES'({r_mosi_sync, mosi});
      r_armed     <= r_armed | (w_cs_vld & w_cs_level);
      r_we        <= 1'b0;
      if (w_frame_start) begin
        r_busy      <= 1'b1;
        r_frame_err <= 1'b0;
        r_bit_cnt   <= 3'd0;
      end else if (w_cs_rise) begin
        r_busy      <= 1'b0;
        r_bit_cnt   <= 3'd0;
      end else if (w_sclk_rise && w_in_frame) begin
        r_shift   <= w_byte[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_byte_done) begin
          if (r_state == ST_CMD) begin
            r_rw       <= w_byte[CMD_RW_BIT];
            r_cur_addr <= ADDR_WIDTH'(w_byte[CMD_ADDR_MSB:CMD_ADDR_LSB]);
`ifndef SPI_READBACK_EN
            if (w_byte[CMD_RW_BIT]) r_frame_err <= 1'b1;
`endif
          end else if (!w_in_range) begin
            // Address saturates here: no wrap, every further byte is an error.
            r_frame_err <= 1'b1;
          end else begin
            r_cur_addr <= r_cur_addr + ADDR_WIDTH'(1);
            if (!r_rw) begin
              r_we   <= 1'b1;
              r_addr <= r_cur_addr;
              r_data <= w_byte;
            end
          end
        end
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic       r_miso;
  logic [6:0] r_tx;
  logic [7:0] w_rd_byte;

  assign w_rd_byte = w_in_range ? rd_data : 8'h00;
  assign rd_addr   = r_cur_addr;

  // Byte is fetched on the first falling sclk of each read byte so its MSB
  // is on miso before the first rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_miso <= 1'b0;
      r_tx   <= 7'd0;
    end else if (w_frame_start || w_cs_rise) begin
      r_miso <= 1'b0;
      r_tx   <= 7'd0;
    end else if (w_sclk_fall && (r_state == ST_DATA) && r_rw) begin
      if (r_bit_cnt == 3'd0) begin
        r_miso <= w_rd_byte[7];
        r_tx   <= w_rd_byte[6:0];
      end else begin
        r_miso <= r_tx[6];
        r_tx   <= {r_tx[5:0], 1'b0};
      end
    end
  end

  assign miso = r_miso;
`else
  assign miso = 1'b0;
`endif

  logic w_unused;
  assign w_unused = ^{w_sclk_level, w_sclk_vld
`ifndef SPI_READBACK_EN
                      , w_sclk_fall
`endif
                     };

  assign we        = r_we;
  assign addr      = r_addr;
  assign data_in   = r_data;
  assign busy      = r_busy;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: frame-level model of expected writes and
// error flag, checked by a per-cycle compare process plus literal pins.
module tb_spi_reg_bridge;

  localparam int AW = 31;
  localparam int NR = 31;
  localparam int SS = 2;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic sclk = 1'b0;
  logic cs_n = 1'b1;
  logic mosi = 1'b0;
  logic          miso, we, busy, frame_err;
  logic [AW-1:0] addr;
  logic [7:0]    data_in;
`ifdef SPI_READBACK_EN
  logic [7:0]    rd_data = 8'h8E;
  logic [AW-1:0] rd_addr;
`endif

  always #5 clk = ~clk;

  spi_reg_bridge #(.ADDR_WIDTH(AW), .NUM_REGS(NR), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .we(we), .addr(addr), .data_in(data_in), .busy(busy), .frame_err(frame_err)
`ifdef SPI_READBACK_EN
    , .rd_data(rd_data), .rd_addr(rd_addr)
`endif
  );

  typedef struct {
    int unsigned a;
    logic [7:0]  d;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         exp_q[$];
  wr_t         wlog[$];
  logic        exp_err = 1'b0;
  int unsigned hold_a = 0;
  logic [7:0]  hold_d = 8'h00;
  logic        prev_we = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst) begin
      chk("reset_outputs", {21'd0, we, addr, data_in, busy, frame_err, miso}, 64'd0);
      hold_a  = 0;
      hold_d  = 8'h00;
      prev_we = 1'b0;
    end else begin
      if (we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_we", {32'd0, 1'b0, addr}, 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("we_addr", {33'd0, addr}, {32'd0, e.a});
          chk("we_data", {56'd0, data_in}, {56'd0, e.d});
        end
        chk("we_one_cycle", {63'd0, prev_we}, 64'd0);
        hold_a = {1'b0, addr};
        hold_d = data_in;
        e.a = {1'b0, addr};
        e.d = data_in;
        wlog.push_back(e);
      end else begin
        chk("hold_addr_data", {24'd0, 1'b0, addr, data_in}, {24'd0, hold_a, hold_d});
      end
`ifndef SPI_READBACK_EN
      chk("miso_idle", {63'd0, miso}, 64'd0);
`endif
      prev_we = we;
    end
  end

  // Frame-level model: which writes a frame must produce and whether it errs.
  task automatic model_frame(input logic [7:0] cmd, input logic [31:0] bytes, input int nfull);
    int unsigned a;
    wr_t w;
    a = {27'd0, cmd[4:0]};
    exp_err = 1'b0;
`ifndef SPI_READBACK_EN
    if (cmd[7]) exp_err = 1'b1;
`endif
    for (int i = 0; i < nfull; i++) begin
      if (a >= NR) begin
        exp_err = 1'b1;
      end else begin
        if (!cmd[7]) begin
          w.a = a;
          w.d = bytes[31-8*i -: 8];
          exp_q.push_back(w);
        end
        a++;
      end
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = b[7-i];
      #80;
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      #80;
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [31:0] bytes, input int nfull,
                       input int pbits, output logic [7:0] rx);
    logic [7:0] junk;
    wlog.delete();
    model_frame(cmd, bytes, nfull);
    cs_n = 1'b0;
    #160;
    send_bits(cmd, 8, rx);
    chk("busy_in_frame", {63'd0, busy}, 64'd1);
    for (int i = 0; i < nfull; i++) send_bits(bytes[31-8*i -: 8], 8, rx);
    if (pbits > 0) send_bits(bytes[31-8*nfull -: 8], pbits, junk);
    #80;
    cs_n = 1'b1;
    #200;
    chk("writes_drained", {32'd0, exp_q.size()}, 64'd0);
    chk("busy_after_frame", {63'd0, busy}, 64'd0);
    chk("frame_err_model", {63'd0, frame_err}, {63'd0, exp_err});
  endtask

  // Literal pin: the log must hold n writes at consecutive addresses from a0.
  task automatic chk_log(input string nm, input int n, input int unsigned a0, input logic [31:0] ds);
    chk({nm, "_count"}, {32'd0, wlog.size()}, {32'd0, n});
    for (int i = 0; i < n && i < wlog.size(); i++)
      chk({nm, "_entry"}, {24'd0, wlog[i].a, wlog[i].d}, {24'd0, a0 + i, ds[31-8*i -: 8]});
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] junk;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (5) @(negedge clk);

    frame(8'h00, 32'hAA00_0000, 1, 0, rx);
    chk_log("single_write", 1, 0, 32'hAA00_0000);

    frame(8'h04, 32'hC771_1C00, 3, 0, rx);
    chk_log("burst_4_5_6", 3, 4, 32'hC771_1C00);

    frame(8'h1D, 32'hFFFF_FF00, 3, 0, rx);
    chk_log("end_of_map", 2, 29, 32'hFFFF_0000);
    chk("end_of_map_err", {63'd0, frame_err}, 64'd1);

    frame(8'h01, 32'hB500_0000, 0, 5, rx);
    chk_log("partial_byte", 0, 0, 32'h0);
    chk("partial_err_cleared", {63'd0, frame_err}, 64'd0);
    chk("partial_busy", {63'd0, busy}, 64'd0);

    wlog.delete();
    exp_q.delete();
    cs_n = 1'b0;
    #160;
    send_bits(8'h02, 8, junk);
    send_bits(8'h66, 3, junk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("reset_immediate", {21'd0, we, addr, data_in, busy, frame_err, miso}, 64'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    send_bits(8'h30, 5, junk);
    #80;
    cs_n = 1'b1;
    #200;
    chk_log("reset_abort", 0, 0, 32'h0);
    chk("reset_abort_busy", {63'd0, busy}, 64'd0);
    chk("reset_abort_err", {63'd0, frame_err}, 64'd0);
    frame(8'h0A, 32'h5C00_0000, 1, 0, rx);
    chk_log("after_reset", 1, 10, 32'h5C00_0000);

`ifdef SPI_READBACK_EN
    frame(8'h87, 32'h0000_0000, 1, 0, rx);
    chk("readback_miso", {56'd0, rx}, {56'd0, 8'h8E});
    chk_log("readback", 0, 0, 32'h0);
    chk("readback_err", {63'd0, frame_err}, 64'd0);
`else
    frame(8'h85, 32'h3300_0000, 1, 0, rx);
    chk_log("read_cmd", 0, 0, 32'h0);
    chk("read_cmd_err", {63'd0, frame_err}, 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
